// File: rtl/ym3438_pkg.sv
// Shared constants and types for the YM3438 timing and LFO configuration blocks.
package ym3438_pkg;
  localparam int         YM_SLOTS    = 24;
  localparam int         YM_CHANNELS = 6;
  localparam logic [7:0] YM_REG_TEST = 8'h21;
  localparam logic [7:0] YM_REG_LFO  = 8'h22;

  typedef logic [4:0] slot_t;
endpackage

// File: rtl/ym3438_phase_gen.sv
// Phase counter dividing MCLK into one operator slot; emits one-MCLK c1/c2 enables
// and a last_ph strobe marking the final MCLK of the slot.
module ym3438_phase_gen #(
  parameter int CLK_DIV = 6
) (
  input  logic clk,
  input  logic rst_n,
  output logic c1,
  output logic c2,
  output logic last_ph
);
  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] ph;

  assign last_ph = (ph == PW'(CLK_DIV - 1));

  // c1/c2 are registered from the current ph, so c1 appears on the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
      c1 <= 1'b0;
      c2 <= 1'b0;
    end else begin
      ph <= last_ph ? '0 : ph + PW'(1);
      c1 <= (ph == '0);
      c2 <= (ph == PW'(CLK_DIV / 2));
    end
  end
endmodule

// File: rtl/ym3438_lfo_sched.sv
// Slot sequencer and LFO/test register port: writes are staged and only committed
// on the last-slot wrap so the LFO never sees a mid-cycle configuration change.
module ym3438_lfo_sched
  import ym3438_pkg::*;
#(
  parameter int         CLK_DIV   = 6,
  parameter int         SLOTS     = YM_SLOTS,
  parameter logic [7:0] ADDR_TEST = YM_REG_TEST,
  parameter logic [7:0] ADDR_LFO  = YM_REG_LFO
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       c1,
  output logic       c2,
  output slot_t      slot,
  output logic [2:0] ch_sel,
  output logic [1:0] op_sel,
  output logic       fsm_sel23,
  output logic [3:0] lfo,
  output logic [7:0] reg_21,
  output logic       cfg_pend
);
  logic       last_ph;
  logic       slot_wrap, ch_wrap, commit;
  slot_t      slot_nxt;
  logic [2:0] ch_nxt;
  logic [1:0] op_nxt;
  logic       accept, wr_lfo, wr_21;
  logic [3:0] pend_lfo;
  logic [7:0] pend_21;
  logic       pend_lfo_v, pend_21_v;
  logic       pend_lfo_v_nxt, pend_21_v_nxt;

  ym3438_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk     (MCLK),
    .rst_n   (IC),
    .c1      (c1),
    .c2      (c2),
    .last_ph (last_ph)
  );

  // ch/op wrap on their own; slot wrap forces both back to 0 so they stay aligned.
  always_comb begin
    slot_wrap = (slot == slot_t'(SLOTS - 1));
    ch_wrap   = (ch_sel == 3'(YM_CHANNELS - 1));
    slot_nxt  = slot_wrap ? '0 : slot + 5'd1;
    ch_nxt    = (slot_wrap || ch_wrap) ? 3'd0 : ch_sel + 3'd1;
    op_nxt    = slot_wrap ? 2'd0 : (ch_wrap ? op_sel + 2'd1 : op_sel);
    commit    = last_ph && slot_wrap;
  end

  // Handshake: wr_req is held until wr_ack; a request is taken on any edge with
  // wr_req=1 and wr_ack=0, and wr_ack is high for exactly the following MCLK.
  always_comb begin
    accept         = wr_req && !wr_ack;
    wr_lfo         = accept && (wr_addr == ADDR_LFO);
    wr_21          = accept && (wr_addr == ADDR_TEST);
    pend_lfo_v_nxt = wr_lfo ? 1'b1 : (commit ? 1'b0 : pend_lfo_v);
    pend_21_v_nxt  = wr_21  ? 1'b1 : (commit ? 1'b0 : pend_21_v);
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      slot      <= '0;
      ch_sel    <= '0;
      op_sel    <= '0;
      fsm_sel23 <= 1'b0;
    end else if (last_ph) begin
      slot      <= slot_nxt;
      ch_sel    <= ch_nxt;
      op_sel    <= op_nxt;
      fsm_sel23 <= (slot_nxt == slot_t'(SLOTS - 1));
    end
  end

  // Commit reads pending contents from before this edge; a same-edge write stays pending.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      wr_ack     <= 1'b0;
      pend_lfo   <= '0;
      pend_21    <= '0;
      pend_lfo_v <= 1'b0;
      pend_21_v  <= 1'b0;
      lfo        <= '0;
      reg_21     <= '0;
      cfg_pend   <= 1'b0;
    end else begin
      wr_ack     <= accept;
      pend_lfo_v <= pend_lfo_v_nxt;
      pend_21_v  <= pend_21_v_nxt;
      cfg_pend   <= pend_lfo_v_nxt | pend_21_v_nxt;
      if (wr_lfo) pend_lfo <= wr_data[3:0];
      if (wr_21)  pend_21  <= wr_data;
      if (commit && pend_lfo_v) lfo    <= pend_lfo;
      if (commit && pend_21_v)  reg_21 <= pend_21;
    end
  end
endmodule

// File: tb/tb_ym3438_lfo_sched.sv
// Directed bench for ym3438_lfo_sched: edge-indexed cadence model plus queued
// expectations for write acknowledges and cycle-wrap commits.
module tb_ym3438_lfo_sched;
  logic       MCLK = 1'b0;
  logic       IC = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, c1, c2, fsm_sel23, cfg_pend;
  logic [4:0] slot;
  logic [2:0] ch_sel;
  logic [1:0] op_sel;
  logic [3:0] lfo;
  logic [7:0] reg_21;

  int n_checks = 0;
  int n_fail   = 0;
  int e;                   // MCLK edges since IC released
  logic [12:0] exp_q[$];   // {cfg_pend, reg_21, lfo} expected after each wrap
  logic [12:0] ack_q[$];   // {cfg_pend, reg_21, lfo} expected with each wr_ack

  // ---------------- clock / reset ----------------
  always #5 MCLK = ~MCLK;

  always @(posedge MCLK or negedge IC) begin
    if (!IC) e <= 0;
    else     e <= e + 1;
  end

  ym3438_lfo_sched dut (
    .MCLK      (MCLK),
    .IC        (IC),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .c1        (c1),
    .c2        (c2),
    .slot      (slot),
    .ch_sel    (ch_sel),
    .op_sel    (op_sel),
    .fsm_sel23 (fsm_sel23),
    .lfo       (lfo),
    .reg_21    (reg_21),
    .cfg_pend  (cfg_pend)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic goto_edge(input int n);
    int guard;
    guard = 0;
    while (e < n && guard < 5000) begin
      @(posedge MCLK);
      #2;
      guard++;
    end
    if (e != n) begin
      n_checks++;
      n_fail++;
      $display("FAIL goto_edge: got edge %0d expected %0d", e, n);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input logic [12:0] exp_ack);
    int guard;
    ack_q.push_back(exp_ack);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    guard   = 0;
    do begin
      @(posedge MCLK);
      #2;
      guard++;
    end while (!wr_ack && guard < 20);
    if (!wr_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: addr %h got no wr_ack", a);
    end
    wr_req = 1'b0;
  endtask

  // ---------------- monitors / scoreboard ----------------
  int         s_exp;
  logic       fsm_prev = 1'b0;
  int         last_rise = -1;
  logic [4:0] prev_slot = 5'd0;
  logic [12:0] got;

  always @(negedge MCLK) begin
    s_exp = (e / 6) % 24;
    check("cadence", {c1, c2, slot, ch_sel, op_sel, fsm_sel23},
          {(e % 6 == 1), (e % 6 == 4), 5'(s_exp), 3'(s_exp % 6), 2'(s_exp / 6), (s_exp == 23)});
    if (!IC) last_rise = -1;
    if (IC && fsm_sel23 && !fsm_prev) begin
      check("fsm_rise_edge", e % 144, 138);
      if (last_rise >= 0) check("fsm_period", e - last_rise, 144);
      last_rise = e;
    end
    fsm_prev = fsm_sel23;
  end

  always @(negedge MCLK) begin
    got = {cfg_pend, reg_21, lfo};
    if (IC && prev_slot == 5'd23 && slot == 5'd0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_unexpected: got %h with no expectation queued", got);
      end else begin
        check("wrap_commit", got, exp_q.pop_front());
      end
    end
    prev_slot = slot;
  end

  always @(negedge MCLK) begin
    if (wr_ack) begin
      if (ack_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ack_unexpected: got %h with no write issued", {cfg_pend, reg_21, lfo});
      end else begin
        check("ack_state", {cfg_pend, reg_21, lfo}, ack_q.pop_front());
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (10) begin
      @(negedge MCLK);
      check("reset_outputs",
            {wr_ack, c1, c2, slot, ch_sel, op_sel, fsm_sel23, lfo, reg_21, cfg_pend}, 32'd0);
    end
    @(posedge MCLK);
    #2 IC = 1'b1;

    exp_q.push_back({1'b0, 8'h00, 4'h0});        // wrap at 144: nothing written yet

    // 0x22=0x0B during slot 5 of the second cycle
    goto_edge(174);
    exp_q.push_back({1'b0, 8'h00, 4'hB});        // wrap at 288
    cpu_write(8'h22, 8'h0B, {1'b1, 8'h00, 4'h0});
    goto_edge(287);
    check("lfo_held_until_wrap", {cfg_pend, lfo}, {1'b1, 4'h0});

    // two LFO writes plus a test-register write before one wrap
    exp_q.push_back({1'b0, 8'h01, 4'hC});        // wrap at 432
    goto_edge(299);
    cpu_write(8'h22, 8'h09, {1'b1, 8'h00, 4'hB});
    cpu_write(8'h22, 8'h0C, {1'b1, 8'h00, 4'hB});
    cpu_write(8'h21, 8'h01, {1'b1, 8'h00, 4'hB});
    goto_edge(431);
    check("pre_wrap_lfo", {cfg_pend, reg_21, lfo}, {1'b1, 8'h00, 4'hB});

    // write accepted on the wrap edge itself
    exp_q.push_back({1'b1, 8'h01, 4'hC});        // wrap at 576: new write stays pending
    exp_q.push_back({1'b0, 8'h01, 4'hF});        // wrap at 720
    goto_edge(575);
    cpu_write(8'h22, 8'h0F, {1'b1, 8'h01, 4'hC});
    goto_edge(719);
    check("wrap_edge_write_pending", {cfg_pend, lfo}, {1'b1, 4'hC});

    // unmapped address: acked, no state change
    exp_q.push_back({1'b0, 8'h01, 4'hF});        // wrap at 864
    goto_edge(730);
    cpu_write(8'h30, 8'hFF, {1'b0, 8'h01, 4'hF});

    // IC pulse at slot 12 with a write pending
    goto_edge(870);
    cpu_write(8'h22, 8'h05, {1'b1, 8'h01, 4'hF});
    goto_edge(936);
    check("slot_before_ic", slot, 12);
    IC = 1'b0;
    #1;
    check("async_clear",
          {wr_ack, c1, c2, slot, ch_sel, op_sel, fsm_sel23, lfo, reg_21, cfg_pend}, 32'd0);
    @(negedge MCLK);
    check("ic_low_outputs",
          {wr_ack, c1, c2, slot, ch_sel, op_sel, fsm_sel23, lfo, reg_21, cfg_pend}, 32'd0);
    @(posedge MCLK);
    #2 IC = 1'b1;
    exp_q.push_back({1'b0, 8'h00, 4'h0});        // pending write must have been lost
    goto_edge(150);
    check("after_ic_lfo", {cfg_pend, reg_21, lfo}, 13'd0);

    check("exp_q_drained", exp_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
